// File: rtl/demux32_1_reg_pkg.sv
// Shared constants for the registered 1:2 word demultiplexer.
// Select encoding and default datapath width.
package demux32_1_reg_pkg;

  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;
  localparam int   DATA_W   = 32;

endpackage

// File: rtl/demux_fifo.sv
// Small circular FIFO with occupancy count.
// Head word reads as zero while the FIFO is empty.
module demux_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PONE  = 1;
  localparam logic [AW:0]   CONE  = 1;
  localparam logic [AW:0]   FULLC = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign valid_o = (cnt_q != '0);
  assign full_o  = (cnt_q == FULLC);
  assign count_o = cnt_q;
  assign data_o  = valid_o ? mem_q[rptr_q] : '0;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & valid_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + PONE;
    if (do_pop)  rptr_d = rptr_q + PONE;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CONE;
      2'b01:   cnt_d = cnt_q - CONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is left uncleared; the head mux hides stale entries.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/demux32_1_reg.sv
// Registered 1:2 demultiplexer: one valid/ready source
// steered by a per-word select into two independent FIFOs.
module demux32_1_reg
  import demux32_1_reg_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out0_data,
  output logic                   out0_valid,
  input  logic                   out0_ready,
  output logic [WIDTH-1:0]       out1_data,
  output logic                   out1_valid,
  input  logic                   out1_ready,
  output logic [$clog2(DEPTH):0] count0,
  output logic [$clog2(DEPTH):0] count1
);

  logic full0, full1;
  logic push0, push1;

  // Readiness ignores the sink readies: a full FIFO never
  // takes a word, even when it pops on the same edge.
  assign in_ready = rst_n &
    ~((in_sel == SEL_OUT1) ? full1 : full0);

  assign push0 = in_valid & in_ready & (in_sel == SEL_OUT0);
  assign push1 = in_valid & in_ready & (in_sel == SEL_OUT1);

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push0),
    .data_i  (in_data),
    .pop_i   (out0_ready),
    .data_o  (out0_data),
    .valid_o (out0_valid),
    .full_o  (full0),
    .count_o (count0)
  );

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push1),
    .data_i  (in_data),
    .pop_i   (out1_ready),
    .data_o  (out1_data),
    .valid_o (out1_valid),
    .full_o  (full1),
    .count_o (count1)
  );

endmodule

// File: tb/tb_demux32_1_reg.sv
// Bench for demux32_1_reg: directed scenarios with literal
// expectations plus randomized traffic against a queue model.
module tb_demux32_1_reg;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out0_data, out1_data;
  logic        out0_valid, out1_valid;
  logic        out0_ready = 1'b0;
  logic        out1_ready = 1'b0;
  logic [1:0]  count0, count1;

  int checks = 0;
  int failures = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] got1[$];
  bit          mdl_ok = 0;
  bit          rec = 0;

  demux32_1_reg #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .count0     (count0),
    .count1     (count1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: two word queues, updated per clock edge.
  always @(posedge clk) begin
    bit p0, p1, acc;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      mdl_ok = 1;
    end else if (mdl_ok) begin
      p0  = (q0.size() > 0) && out0_ready;
      p1  = (q1.size() > 0) && out1_ready;
      acc = in_valid && (in_sel ? (q1.size() < DEPTH)
                                : (q0.size() < DEPTH));
      if (rec && p1) got1.push_back(q1[0]);
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (acc) begin
        if (in_sel) q1.push_back(in_data);
        else        q0.push_back(in_data);
      end
    end
  end

  // Compare the DUT against the model every cycle.
  always @(negedge clk) begin
    if (mdl_ok) begin
      logic rdy;
      rdy = rst_n && (in_sel ? (q1.size() < DEPTH)
                             : (q0.size() < DEPTH));
      chk("m_in_ready", {31'b0, in_ready}, {31'b0, rdy});
      chk("m_valid0", {31'b0, out0_valid},
          {31'b0, q0.size() > 0});
      chk("m_valid1", {31'b0, out1_valid},
          {31'b0, q1.size() > 0});
      chk("m_data0", out0_data, q0.size() > 0 ? q0[0] : 32'h0);
      chk("m_data1", out1_data, q1.size() > 0 ? q1[0] : 32'h0);
      chk("m_count0", {30'b0, count0}, q0.size());
      chk("m_count1", {30'b0, count1}, q1.size());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic s,
                     input logic [31:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  initial begin
    bit acc;
    bit hold;
    int n;

    // Reset with a word offered at the input
    rst_n = 0;
    out0_ready = 1;
    out1_ready = 1;
    drv(1, 0, 32'hDEADBEEF);
    for (int i = 0; i < 2; i++) begin
      cyc();
      #2;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
      chk("rst_valid0", {31'b0, out0_valid}, 32'd0);
      chk("rst_valid1", {31'b0, out1_valid}, 32'd0);
      chk("rst_count0", {30'b0, count0}, 32'd0);
      chk("rst_count1", {30'b0, count1}, 32'd0);
      chk("rst_data0", out0_data, 32'd0);
      chk("rst_data1", out1_data, 32'd0);
    end

    // Routing
    rst_n = 1;
    drv(1, 0, 32'h11);
    cyc();
    drv(1, 1, 32'h22);
    #2;
    chk("rt_valid0", {31'b0, out0_valid}, 32'd1);
    chk("rt_data0", out0_data, 32'h11);
    chk("rt_valid1_pre", {31'b0, out1_valid}, 32'd0);
    cyc();
    drv(0, 0, 32'h0);
    #2;
    chk("rt_valid0_post", {31'b0, out0_valid}, 32'd0);
    chk("rt_valid1", {31'b0, out1_valid}, 32'd1);
    chk("rt_data1", out1_data, 32'h22);
    cyc();
    #2;
    chk("rt_valid1_post", {31'b0, out1_valid}, 32'd0);

    // Backpressure on out0, isolation of out1
    out0_ready = 0;
    drv(1, 0, 32'hA1);
    cyc();
    drv(1, 0, 32'hA2);
    cyc();
    drv(1, 0, 32'hA3);
    #2;
    chk("bp_count0", {30'b0, count0}, 32'd2);
    chk("bp_rdy_sel0", {31'b0, in_ready}, 32'd0);
    drv(1, 1, 32'hB1);
    #1;
    chk("bp_rdy_sel1", {31'b0, in_ready}, 32'd1);
    cyc();
    drv(0, 0, 32'h0);
    #2;
    chk("bp_data1", out1_data, 32'hB1);
    chk("bp_valid1", {31'b0, out1_valid}, 32'd1);

    // Full FIFO 0 with a pop on the same edge
    out0_ready = 1;
    drv(1, 0, 32'hA3);
    #1;
    chk("fp_rdy_full", {31'b0, in_ready}, 32'd0);
    chk("fp_head", out0_data, 32'hA1);
    cyc();
    #2;
    chk("fp_count0", {30'b0, count0}, 32'd1);
    chk("fp_head2", out0_data, 32'hA2);
    chk("fp_rdy", {31'b0, in_ready}, 32'd1);
    cyc();
    drv(0, 0, 32'h0);
    #2;
    chk("fp_head3", out0_data, 32'hA3);
    chk("fp_count0b", {30'b0, count0}, 32'd1);
    cyc();
    #2;
    chk("fp_empty", {31'b0, out0_valid}, 32'd0);

    // Wrap-around with a toggling sink
    rec = 1;
    got1.delete();
    out1_ready = 0;
    for (int i = 1; i <= 9; i++) begin
      drv(1, 1, i);
      acc = 0;
      for (int t = 0; t < 20 && !acc; t++) begin
        #1;
        acc = in_ready;
        cyc();
        out1_ready = ~out1_ready;
        chk("wr_cnt_le2", {31'b0, count1 <= 2'd2}, 32'd1);
      end
      chk("wr_accepted", {31'b0, acc}, 32'd1);
    end
    drv(0, 0, 32'h0);
    out1_ready = 1;
    for (int i = 0; i < 4; i++) cyc();
    rec = 0;
    chk("wr_n_recv", got1.size(), 32'd9);
    for (int i = 0; i < 9 && i < got1.size(); i++)
      chk("wr_order", got1[i], i + 1);

    // Reset mid-stream discards buffered words
    out0_ready = 0;
    drv(1, 0, 32'hC1);
    cyc();
    drv(1, 0, 32'hC2);
    cyc();
    drv(0, 0, 32'h0);
    #2;
    chk("mr_count0", {30'b0, count0}, 32'd2);
    rst_n = 0;
    cyc();
    rst_n = 1;
    out0_ready = 1;
    #2;
    chk("mr_valid0", {31'b0, out0_valid}, 32'd0);
    chk("mr_count0b", {30'b0, count0}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      #2;
      chk("mr_stale", {31'b0, out0_valid}, 32'd0);
    end

    // Randomized traffic with occasional resets
    hold = 0;
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!hold) begin
        drv(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
            $urandom);
      end
      out0_ready = ($urandom_range(0, 2) != 0);
      out1_ready = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      #1;
      hold = in_valid && !in_ready && rst_n;
      if (in_valid && in_ready) n++;
      cyc();
    end
    rst_n = 1;
    drv(0, 0, 32'h0);
    cyc();
    chk("rnd_traffic", {31'b0, n > 500}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
